// File: rtl/sdpram_fifo_ctrl.sv
// sdpram_fifo_ctrl
//   FIFO controller wrapped around an external simple dual-port RAM whose
//   read data comes back a fixed number of cycles after the request, tagged
//   by ram_dvalb. The controller owns the RAM pointers and occupancy. It
//   limits outstanding reads with a credit count so that every returning
//   word has a slot in a small output buffer. That buffer hides the RAM
//   read latency from the consumer.
//
// Ports
//   clk, rst         clock (posedge) and asynchronous active-high reset
//   flush            pulse: discard everything held (honoured in RUN only)
//   s_valid/s_ready  write stream handshake, s_data is the write word
//   m_valid/m_ready  read stream handshake, m_data is the output buffer head
//   count            words held in RAM + reads in flight + output buffer
//   full / empty     RAM has no free entry / count is zero
//   ram_wena/addra/dina        RAM write port (straight from the write side)
//   ram_renb/addrb             RAM read request
//   ram_doutb/dvalb            RAM read return
module sdpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int RD_LATENCY = 3,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [DATA_WIDTH-1:0]                        s_data,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [DATA_WIDTH-1:0]                        m_data,
  output logic [$clog2(MEM_DEPTH+OBUF_DEPTH+1)-1:0]    count,
  output logic                                         full,
  output logic                                         empty,
  output logic                                         ram_wena,
  output logic [ADDR_WIDTH-1:0]                        ram_addra,
  output logic [DATA_WIDTH-1:0]                        ram_dina,
  output logic                                         ram_renb,
  output logic [ADDR_WIDTH-1:0]                        ram_addrb,
  input  logic [DATA_WIDTH-1:0]                        ram_doutb,
  input  logic                                         ram_dvalb
);

  localparam int MC_W  = $clog2(MEM_DEPTH + 1);
  // Generous bound: in-flight reads can never exceed the buffer credits,
  // but sizing against the RAM latency as well keeps it safe if either
  // parameter is changed on its own.
  localparam int INF_W = $clog2(RD_LATENCY + OBUF_DEPTH + 1);
  localparam int OC_W  = $clog2(OBUF_DEPTH + 1);
  localparam int OA_W  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(MEM_DEPTH + OBUF_DEPTH + 1);

  localparam logic [MC_W-1:0]  MEM_FULL = MC_W'(MEM_DEPTH);
  localparam logic [INF_W:0]   OB_LIM   = (INF_W+1)'(OBUF_DEPTH);
  localparam logic [OA_W-1:0]  OB_LAST  = OA_W'(OBUF_DEPTH - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [MC_W-1:0]        mem_cnt_q, mem_cnt_d;
  logic [INF_W-1:0]       inflight_q, inflight_d;
  logic [OC_W-1:0]        obuf_cnt_q, obuf_cnt_d;
  logic [OA_W-1:0]        obuf_wr_q, obuf_wr_d;
  logic [OA_W-1:0]        obuf_rd_q, obuf_rd_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0]  obuf_q [OBUF_DEPTH];

  logic                   run;
  logic [INF_W:0]         credit_used;
  logic                   accept, issue, ret, push, pop, enter_flush;

  // Every outstanding read plus every buffered word holds one credit.
  assign credit_used = {1'b0, inflight_q} + (INF_W+1)'(obuf_cnt_q);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      // Stay here until every read already sent to the RAM has come back,
      // so stale returns never land in the output buffer.
      ST_FLUSH: if (inflight_q == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM: outputs. rst gates the handshakes directly so nothing is offered
  // while reset is held, and s_ready rises as soon as it is released.
  always_comb begin
    run      = (state_q == ST_RUN) && !rst;
    s_ready  = run && (mem_cnt_q != MEM_FULL);
    ram_wena = s_valid && s_ready;
    ram_renb = run && (mem_cnt_q != '0) && (credit_used < OB_LIM);
    m_valid  = run && (obuf_cnt_q != '0);
  end

  assign ram_addra = wr_ptr_q;
  assign ram_dina  = s_data;
  assign ram_addrb = rd_ptr_q;
  assign m_data    = obuf_q[obuf_rd_q];
  assign count     = count_q;
  assign full      = (mem_cnt_q == MEM_FULL);
  assign empty     = (count_q == '0);

  always_comb begin
    accept      = ram_wena;
    issue       = ram_renb;
    // The RAM read pipeline is not reset, so a return with nothing
    // outstanding is leftover from before a reset and is dropped.
    ret         = ram_dvalb && (inflight_q != '0);
    push        = ret && (state_q == ST_RUN);
    pop         = m_valid && m_ready;
    enter_flush = (state_q == ST_RUN) && flush;

    wr_ptr_d   = accept ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d   = issue  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    mem_cnt_d  = mem_cnt_q + MC_W'(accept) - MC_W'(issue);
    inflight_d = inflight_q + INF_W'(issue) - INF_W'(ret);
    obuf_cnt_d = obuf_cnt_q + OC_W'(push) - OC_W'(pop);

    obuf_wr_d = obuf_wr_q;
    if (push) obuf_wr_d = (obuf_wr_q == OB_LAST) ? '0 : obuf_wr_q + OA_W'(1);
    obuf_rd_d = obuf_rd_q;
    if (pop)  obuf_rd_d = (obuf_rd_q == OB_LAST) ? '0 : obuf_rd_q + OA_W'(1);

    // Flush drops everything held locally, including a write or a push
    // taken on the flush edge itself. Reads already issued stay counted
    // in inflight so they can be drained.
    if (enter_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mem_cnt_d  = '0;
      obuf_cnt_d = '0;
      obuf_wr_d  = '0;
      obuf_rd_d  = '0;
    end

    count_d = CNT_W'(mem_cnt_d) + CNT_W'(inflight_d) + CNT_W'(obuf_cnt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= '0;
      obuf_cnt_q <= '0;
      obuf_wr_q  <= '0;
      obuf_rd_q  <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf_wr_q  <= obuf_wr_d;
      obuf_rd_q  <= obuf_rd_d;
      count_q    <= count_d;
    end
  end

  // Output buffer storage: data only, validity lives in obuf_cnt_q.
  always_ff @(posedge clk) begin
    if (push) obuf_q[obuf_wr_q] <= ram_doutb;
  end

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
module tb_sdpram_fifo_ctrl;

  localparam int DW = 8;
  localparam int MD = 16;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          rst, flush, s_valid, m_ready;
  logic          s_ready, m_valid, full, empty;
  logic [DW-1:0] s_data, m_data;
  logic [4:0]    count;
  logic          ram_wena, ram_renb, ram_dvalb;
  logic [3:0]    ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  sdpram_fifo_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .RD_LATENCY(3), .OBUF_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .empty(empty),
    .ram_wena(ram_wena), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_renb(ram_renb), .ram_addrb(ram_addrb),
    .ram_doutb(ram_doutb), .ram_dvalb(ram_dvalb)
  );

  // RAM model: request sampled at edge E, data/valid presented after edge E+3.
  logic [DW-1:0] ram_mem [MD];
  logic [3:0]    pv = '0;
  logic [DW-1:0] pd [4];
  always @(posedge clk) begin
    if (ram_wena) ram_mem[ram_addra] <= ram_dina;
    pv    <= {pv[2:0], ram_renb};
    pd[0] <= ram_mem[ram_addrb];
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end
  assign ram_dvalb = pv[3];
  assign ram_doutb = pd[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Samples handshakes just before the next edge, then advances one cycle.
  task automatic tick(output bit acc, output bit pp, output logic [DW-1:0] md, output bit dv);
    #1;
    acc = s_valid && s_ready;
    pp  = m_valid && m_ready;
    md  = m_data;
    dv  = ram_dvalb;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; s_valid = 1; s_data = 8'h5A; m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (ram_wena !== 1'b0) begin n_fail++; $display("FAIL rst_wena: got %b want 0", ram_wena); end
    n_cmp++; if (ram_renb !== 1'b0) begin n_fail++; $display("FAIL rst_renb: got %b want 0", ram_renb); end
    n_cmp++; if (count !== 5'd0)    begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0)     begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
    s_valid = 0;
    rst = 0;
    #1;
    n_cmp++; if (s_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_release_s_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit a, p, dv; logic [DW-1:0] d;
    s_valid = 1; s_data = 8'hA5; m_ready = 1;
    tick(a, p, d, dv);
    s_valid = 0;
    n_cmp++; if (a !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", a); end
    for (int k = 0; k <= 5; k++) begin
      n_cmp++;
      if (m_valid !== (k == 5)) begin n_fail++; $display("FAIL single_latency k=%0d: m_valid got %b want %b", k, m_valid, (k == 5)); end
      if (k < 5) tick(a, p, d, dv);
    end
    n_cmp++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", m_data); end
    tick(a, p, d, dv);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", empty); end
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", count); end
  endtask

  task automatic test_stream();
    bit a, p, dv; logic [DW-1:0] d;
    int sent = 0, got = 0, cyc = 0;
    exp_q.delete();
    m_ready = 1;
    while (got < 64 && cyc < 1000) begin
      s_valid = (sent < 64); s_data = 8'(sent);
      tick(a, p, d, dv); cyc++;
      if (a) begin exp_q.push_back(8'(sent)); sent++; end
      if (p) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_data: got %h want none", d); end
        else begin
          if (d !== exp_q[0]) begin n_fail++; $display("FAIL stream_data: got %h want %h", d, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      n_cmp++; if (int'(count) != exp_q.size()) begin n_fail++; $display("FAIL stream_count: got %0d want %0d", count, exp_q.size()); end
    end
    s_valid = 0;
    n_cmp++; if (got != 64) begin n_fail++; $display("FAIL stream_total: got %0d want 64", got); end
  endtask

  task automatic test_fill();
    bit a, p, dv; logic [DW-1:0] d;
    int sent = 0, got = 0, cyc = 0;
    exp_q.delete();
    m_ready = 0;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1; s_data = 8'(sent);
      tick(a, p, d, dv);
      if (a) begin exp_q.push_back(8'(sent)); sent++; end
    end
    s_valid = 0;
    n_cmp++; if (sent != MD + OD) begin n_fail++; $display("FAIL fill_accepted: got %0d want %0d", sent, MD + OD); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (full !== 1'b1)    begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    n_cmp++; if (count !== 5'd20)  begin n_fail++; $display("FAIL fill_count: got %0d want 20", count); end
    m_ready = 1;
    while (exp_q.size() > 0 && cyc < 200) begin
      tick(a, p, d, dv); cyc++;
      if (p) begin
        n_cmp++;
        if (d !== exp_q[0]) begin n_fail++; $display("FAIL fill_data: got %h want %h", d, exp_q[0]); end
        void'(exp_q.pop_front());
        got++;
      end
    end
    n_cmp++; if (got != MD + OD) begin n_fail++; $display("FAIL fill_drained: got %0d want %0d", got, MD + OD); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b want 1", empty); end
  endtask

  task automatic test_random();
    bit a, p, dv; logic [DW-1:0] d, sd;
    int pv_pct, pr_pct, cyc = 0;
    exp_q.delete();
    for (int i = 0; i < 10000; i++) begin
      case ((i / 1000) % 3)
        0: begin pv_pct = 30; pr_pct = 90; end
        1: begin pv_pct = 95; pr_pct = 20; end
        default: begin pv_pct = 70; pr_pct = 60; end
      endcase
      sd = 8'($urandom);
      s_valid = ($urandom_range(99) < pv_pct); s_data = sd;
      m_ready = ($urandom_range(99) < pr_pct);
      #1;
      // RAM occupancy never exceeds total held, and total never exceeds capacity.
      if (exp_q.size() < MD) begin
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rand_s_ready_hi: got %b want 1 held=%0d", s_ready, exp_q.size()); end
      end else if (exp_q.size() >= MD + OD) begin
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rand_s_ready_lo: got %b want 0 held=%0d", s_ready, exp_q.size()); end
      end
      tick(a, p, d, dv);
      if (a) exp_q.push_back(sd);
      if (p) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_data: got %h want none", d); end
        else begin
          if (d !== exp_q[0]) begin n_fail++; $display("FAIL rand_data: got %h want %h", d, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      n_cmp++; if (int'(count) != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", count, exp_q.size()); end
      n_cmp++; if (empty !== (exp_q.size() == 0)) begin n_fail++; $display("FAIL rand_empty: got %b want %b", empty, (exp_q.size() == 0)); end
    end
    s_valid = 0; m_ready = 1;
    while (exp_q.size() > 0 && cyc < 500) begin
      tick(a, p, d, dv); cyc++;
      if (p) begin
        n_cmp++;
        if (d !== exp_q[0]) begin n_fail++; $display("FAIL rand_drain: got %h want %h", d, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    bit a, p, dv; logic [DW-1:0] d;
    int seen = 0, cyc = 0, acc_n = 0;
    m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = 8'(8'h31 + i);
      tick(a, p, d, dv);
      acc_n += int'(a);
    end
    s_valid = 0;
    n_cmp++; if (acc_n != 3) begin n_fail++; $display("FAIL flush_setup: got %0d want 3", acc_n); end
    tick(a, p, d, dv);
    // Flush with a same-cycle write that must be discarded.
    flush = 1; s_valid = 1; s_data = 8'h99;
    tick(a, p, d, dv);
    seen += int'(dv);
    flush = 0; s_valid = 0;
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flush_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (int'(count) != $countones(pv)) begin n_fail++; $display("FAIL flush_count_inflight: got %0d want %0d", count, $countones(pv)); end
    while (s_ready !== 1'b1 && cyc < 30) begin
      n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_m_valid: got %b want 0", m_valid); end
      tick(a, p, d, dv); cyc++;
      seen += int'(dv);
    end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_exit: s_ready got %b want 1", s_ready); end
    n_cmp++; if (seen != 3)        begin n_fail++; $display("FAIL flush_returns: got %0d want 3", seen); end
    n_cmp++; if (count !== 5'd0)   begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_m_valid_after: got %b want 0", m_valid); end
    s_valid = 1; s_data = 8'h11; m_ready = 1;
    tick(a, p, d, dv);
    s_valid = 0;
    cyc = 0;
    while (m_valid !== 1'b1 && cyc < 20) begin tick(a, p, d, dv); cyc++; end
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL flush_next_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL flush_next_data: got %h want 11", m_data); end
    tick(a, p, d, dv);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    bit a, p, dv; logic [DW-1:0] d;
    int cyc = 0, got = 0;
    m_ready = 1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1; s_data = 8'(8'h80 + i);
      tick(a, p, d, dv);
    end
    rst = 1;
    #1;
    n_cmp++; if (s_ready !== 1'b0)  begin n_fail++; $display("FAIL rstmid_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL rstmid_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (ram_wena !== 1'b0) begin n_fail++; $display("FAIL rstmid_wena: got %b want 0", ram_wena); end
    n_cmp++; if (ram_renb !== 1'b0) begin n_fail++; $display("FAIL rstmid_renb: got %b want 0", ram_renb); end
    n_cmp++; if (count !== 5'd0)    begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL rstmid_empty: got %b want 1", empty); end
    s_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      tick(a, p, d, dv);
      n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: m_valid got %b want 0", m_valid); end
      n_cmp++; if (count !== 5'd0)   begin n_fail++; $display("FAIL rstmid_stale_count: got %0d want 0", count); end
    end
    for (int i = 1; i <= 2; i++) begin
      s_valid = 1; s_data = 8'(i);
      tick(a, p, d, dv);
      if (a) exp_q.push_back(8'(i));
    end
    s_valid = 0;
    while (got < 2 && cyc < 30) begin
      tick(a, p, d, dv); cyc++;
      if (p) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_data: got %h want none", d); end
        else begin
          if (d !== exp_q[0]) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", d, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
    end
    n_cmp++; if (got != 2)       begin n_fail++; $display("FAIL rstmid_total: got %0d want 2", got); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty_end: got %b want 1", empty); end
  endtask

  initial begin
    rst = 1; flush = 0; s_valid = 0; s_data = '0; m_ready = 0;
    test_reset();
    test_single();
    test_stream();
    test_fill();
    test_random();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
